// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions used by the fetch queue and the main decoder.
// Contents:
//   - instruction-word field slice macros (RV_OPCODE, RV_RD, RV_FUNCT3, RV_RS1, RV_RS2, RV_FUNCT7)
//   - XLEN_DEFAULT         default datapath width
//   - OPC_BRANCH/JAL/JALR  major opcodes for control-transfer instructions
//   - preDecodeT/preDecode control-transfer flags derived from an opcode

`ifndef RISCV_FIELD_MACROS
`define RISCV_FIELD_MACROS
`define RV_OPCODE(w) w[6:0]
`define RV_RD(w)     w[11:7]
`define RV_FUNCT3(w) w[14:12]
`define RV_RS1(w)    w[19:15]
`define RV_RS2(w)    w[24:20]
`define RV_FUNCT7(w) w[31:25]
`endif

package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic isBranch;
        logic isJal;
        logic isJalr;
    } preDecodeT;

    localparam int unsigned PREDECODE_W = 3;

    function automatic preDecodeT preDecode(input logic [6:0] opcode);
        preDecodeT pd;
        pd.isBranch = (opcode == OPC_BRANCH);
        pd.isJal    = (opcode == OPC_JAL);
        pd.isJalr   = (opcode == OPC_JALR);
        return pd;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO with a registered head entry.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   flush                 empty the FIFO (wins over push)
//   push, pushData        write one entry
//   pop                   retire the head entry (ignored when empty)
//   count                 current occupancy
//   headValid, headData   head entry, driven straight from flops; headData is 0 when empty
// The caller guarantees that a push never finds the FIFO full.

module ifq_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     headValid,
    output logic [WIDTH-1:0]         headData
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtrQ, wrPtrD, rdPtrQ, rdPtrD, rdNext;
    logic [CW-1:0]    countQ, countD;
    logic             headValidQ, headValidD;
    logic [WIDTH-1:0] headDataQ, headDataD;
    logic             doPush, doPop;

    assign doPush = push && !flush;
    assign doPop  = pop && headValidQ && !flush;
    assign rdNext = rdPtrQ + AW'(1);

    always_comb begin
        wrPtrD     = wrPtrQ + AW'(doPush);
        rdPtrD     = rdPtrQ + AW'(doPop);
        countD     = countQ + CW'(doPush) - CW'(doPop);
        headValidD = headValidQ;
        headDataD  = headDataQ;
        if (flush) begin
            wrPtrD = '0;
            rdPtrD = '0;
            countD = '0;
        end
        // Head register tracks whatever entry will be at rdPtr next cycle.
        if (countD == '0) begin
            headValidD = 1'b0;
            headDataD  = '0;
        end else if (doPop) begin
            headValidD = 1'b1;
            // With one entry left, the new head can only be the entry pushed now.
            headDataD  = (countQ == CW'(1)) ? pushData : mem[rdNext];
        end else if (!headValidQ) begin
            headValidD = 1'b1;
            headDataD  = pushData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtrQ     <= '0;
            rdPtrQ     <= '0;
            countQ     <= '0;
            headValidQ <= 1'b0;
            headDataQ  <= '0;
        end else begin
            wrPtrQ     <= wrPtrD;
            rdPtrQ     <= rdPtrD;
            countQ     <= countD;
            headValidQ <= headValidD;
            headDataQ  <= headDataD;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtrQ] <= pushData;
        end
    end

    assign count     = countQ;
    assign headValid = headValidQ;
    assign headData  = headDataQ;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues sequential word fetches, buffers in-order responses and
// presents {instr, pc, pc+4} to decode over valid/ready. A redirect flushes the queue and
// discards every response still in flight for the old path.
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   imem_req_valid/addr/ready          fetch request channel (addr word aligned)
//   imem_rsp_valid/data                in-order response channel, never back-pressured
//   redirect_valid/pc                  flush and restart fetch at redirect_pc & ~3
//   id_valid/ready                     decode handshake
//   id_instr, id_pc, id_pcplus4        head entry (all 0 when empty)
//   id_is_branch/jal/jalr              predecoded head flags, only when IFQ_PREDECODE_EN is defined
// Occupancy plus outstanding requests never exceeds DEPTH, so the FIFO cannot overflow.

module ifetch_queue
    import riscv_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pcplus4
`ifdef IFQ_PREDECODE_EN
    ,
    output logic            id_is_branch,
    output logic            id_is_jal,
    output logic            id_is_jalr
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DepthLim = (CW+1)'(DEPTH);
`ifdef IFQ_PREDECODE_EN
    localparam int unsigned FW = 2 * XLEN + PREDECODE_W;
`else
    localparam int unsigned FW = 2 * XLEN;
`endif

    logic [XLEN-1:0] fetchPcQ, fetchPcD;
    logic [CW-1:0]   outstandingQ, outstandingD;
    logic [CW-1:0]   dropQ, dropD;
    logic [AW-1:0]   tagWrQ, tagWrD, tagRdQ, tagRdD;
    logic [XLEN-1:0] pcTag [DEPTH];

    logic [CW-1:0]   fifoCount;
    logic [CW:0]     inFlight;
    logic            reqValid, reqFire;
    logic            rspDrop, rspLive, fifoPush;
    logic [XLEN-1:0] rspPc;
    logic [FW-1:0]   pushData, headData;
    logic            headValid;
    logic            unusedPcBits;

    assign unusedPcBits = ^redirect_pc[1:0];

    // Reserve a FIFO slot for every request before it is issued.
    assign inFlight = {1'b0, fifoCount} + {1'b0, outstandingQ};
    assign reqValid = !reset && !redirect_valid && (inFlight < DepthLim);
    assign reqFire  = reqValid && imem_req_ready;

    // Responses owed to a previous path arrive first and are consumed by dropQ.
    assign rspDrop  = imem_rsp_valid && (dropQ != '0);
    assign rspLive  = imem_rsp_valid && (dropQ == '0);
    assign fifoPush = rspLive && !redirect_valid;

    // Tag queue occupancy equals outstandingQ; when empty the response belongs to the
    // request being accepted this very cycle (zero-latency memory).
    assign rspPc = (outstandingQ == '0) ? fetchPcQ : pcTag[tagRdQ];

    always_comb begin
        fetchPcD     = fetchPcQ;
        outstandingD = outstandingQ;
        dropD        = dropQ;
        tagWrD       = tagWrQ;
        tagRdD       = tagRdQ;
        if (redirect_valid) begin
            fetchPcD     = {redirect_pc[XLEN-1:2], 2'b00};
            outstandingD = '0;
            // Everything still owed by memory for the old path becomes droppable, including
            // a live response arriving now, which is discarded rather than pushed.
            dropD        = dropQ - CW'(rspDrop) + outstandingQ + CW'(reqFire) - CW'(rspLive);
            tagWrD       = '0;
            tagRdD       = '0;
        end else begin
            if (reqFire) begin
                fetchPcD = fetchPcQ + XLEN'(4);
            end
            outstandingD = outstandingQ + CW'(reqFire) - CW'(rspLive);
            dropD        = dropQ - CW'(rspDrop);
            tagWrD       = tagWrQ + AW'(reqFire);
            tagRdD       = tagRdQ + AW'(rspLive);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetchPcQ     <= RESET_PC;
            outstandingQ <= '0;
            dropQ        <= '0;
            tagWrQ       <= '0;
            tagRdQ       <= '0;
        end else begin
            fetchPcQ     <= fetchPcD;
            outstandingQ <= outstandingD;
            dropQ        <= dropD;
            tagWrQ       <= tagWrD;
            tagRdQ       <= tagRdD;
        end
    end

    always_ff @(posedge clk) begin
        if (reqFire) begin
            pcTag[tagWrQ] <= fetchPcQ;
        end
    end

`ifdef IFQ_PREDECODE_EN
    assign pushData = {preDecode(`RV_OPCODE(imem_rsp_data)), imem_rsp_data, rspPc};
`else
    assign pushData = {imem_rsp_data, rspPc};
`endif

    ifq_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (fifoPush),
        .pushData  (pushData),
        .pop       (id_valid && id_ready),
        .count     (fifoCount),
        .headValid (headValid),
        .headData  (headData)
    );

    assign imem_req_valid = reqValid;
    assign imem_req_addr  = fetchPcQ;
    assign id_valid       = headValid;
    assign id_instr       = headData[2*XLEN-1:XLEN];
    assign id_pc          = headData[XLEN-1:0];
    assign id_pcplus4     = headValid ? (headData[XLEN-1:0] + XLEN'(4)) : '0;

`ifdef IFQ_PREDECODE_EN
    preDecodeT headPd;
    assign headPd       = preDecodeT'(headData[FW-1:2*XLEN]);
    assign id_is_branch = headPd.isBranch;
    assign id_is_jal    = headPd.isJal;
    assign id_is_jalr   = headPd.isJalr;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: a latency-configurable memory model tags every
// accepted request with a path generation; responses of the current generation are pushed
// to an expected queue and compared against decode-side output as it appears.

module tb_ifetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pcplus4;
`ifdef IFQ_PREDECODE_EN
    logic        id_is_branch;
    logic        id_is_jal;
    logic        id_is_jalr;
`endif

    always #5 clk = ~clk;

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .XLEN     (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pcplus4     (id_pcplus4)
`ifdef IFQ_PREDECODE_EN
        ,
        .id_is_branch   (id_is_branch),
        .id_is_jal      (id_is_jal),
        .id_is_jalr     (id_is_jalr)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          gen;
        int          due;
    } pendT;

    pendT        pending[$];
    logic [31:0] expq[$];
    int          checks      = 0;
    int          errors      = 0;
    int          cyc         = 0;
    int          curGen      = 0;
    int          lat         = 1;
    int          memReadyPct = 100;
    int          idReadyPct  = 100;
    int          fireCount   = 0;
    int          popCount    = 0;
    logic [31:0] expFetch    = RESET_PC;
    logic [31:0] firstPc     = 32'hFFFF_FFFF;
    bit          usePdTable  = 1'b0;
    bit          wantFirst   = 1'b0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (usePdTable && a < 32'h10) begin
            case (a[3:2])
                2'd0:    return 32'h0000_006F;
                2'd1:    return 32'h0000_8067;
                2'd2:    return 32'h0000_0063;
                default: return 32'h0000_0013;
            endcase
        end
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // One clock cycle: drive inputs at negedge, resolve handshakes, update the model.
    task automatic step(input bit redir, input logic [31:0] rpc);
        pendT        p;
        bit          fire;
        bit          deliver;
        int          due;
        logic [31:0] w;
        @(negedge clk);
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = ($urandom_range(99) < memReadyPct);
        id_ready       = ($urandom_range(99) < idReadyPct);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        deliver        = 1'b0;
        #1;
        fire = imem_req_valid && imem_req_ready;
        if (redir) checkEq("noReqOnRedirect", 32'(imem_req_valid), 32'd0);
        if (fire) begin
            checkEq("reqAddr", imem_req_addr, expFetch);
            expFetch = expFetch + 32'd4;
            due = cyc + lat;
            if (pending.size() != 0 && due < pending[$].due) due = pending[$].due;
            pending.push_back('{addr: imem_req_addr, gen: curGen, due: due});
            fireCount++;
        end
        if (pending.size() != 0 && pending[0].due <= cyc) begin
            p = pending.pop_front();
            deliver        = 1'b1;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memWord(p.addr);
        end
        #1;
        checkEq("idValid", 32'(id_valid), 32'(expq.size() != 0));
        if (id_valid && expq.size() != 0) begin
            w = memWord(expq[0]);
            checkEq("idPc", id_pc, expq[0]);
            checkEq("idInstr", id_instr, w);
            checkEq("idPcPlus4", id_pcplus4, expq[0] + 32'd4);
`ifdef IFQ_PREDECODE_EN
            checkEq("isBranch", 32'(id_is_branch), 32'(w[6:0] == 7'b1100011));
            checkEq("isJal", 32'(id_is_jal), 32'(w[6:0] == 7'b1101111));
            checkEq("isJalr", 32'(id_is_jalr), 32'(w[6:0] == 7'b1100111));
`endif
            if (id_ready) begin
                expq.delete(0);
                popCount++;
                if (wantFirst) begin
                    firstPc   = id_pc;
                    wantFirst = 1'b0;
                end
            end
        end
        if (deliver && p.gen == curGen && !redir) expq.push_back(p.addr);
        if (redir) begin
            expq.delete();
            curGen++;
            expFetch  = rpc & ~32'd3;
            wantFirst = 1'b1;
            firstPc   = 32'hFFFF_FFFF;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        id_ready       = 1'b0;
        pending.delete();
        expq.delete();
        curGen++;
        expFetch  = RESET_PC;
        wantFirst = 1'b0;
        @(negedge clk);
        checkEq("rstReqValid", 32'(imem_req_valid), 32'd0);
        checkEq("rstReqAddr", imem_req_addr, RESET_PC);
        checkEq("rstIdValid", 32'(id_valid), 32'd0);
        checkEq("rstInstr", id_instr, 32'd0);
        checkEq("rstPc", id_pc, 32'd0);
        checkEq("rstPcPlus4", id_pcplus4, 32'd0);
`ifdef IFQ_PREDECODE_EN
        checkEq("rstFlags", {29'd0, id_is_branch, id_is_jal, id_is_jalr}, 32'd0);
`endif
        @(negedge clk);
        reset     = 1'b0;
        fireCount = 0;
        popCount  = 0;
    endtask

    initial begin
        reset = 1'b1;

        // Streaming: one instruction per cycle after the two-cycle fill.
        doReset();
        lat = 1; memReadyPct = 100; idReadyPct = 100;
        run(20);
        checkEq("throughput", 32'(popCount), 32'd18);

        // Decode stall: exactly DEPTH requests, head holds PC 0.
        doReset();
        idReadyPct = 0;
        run(10);
        checkEq("stallReqs", 32'(fireCount), 32'(DEPTH));
        checkEq("stallReqValid", 32'(imem_req_valid), 32'd0);
        checkEq("stallPc", id_pc, 32'd0);
        idReadyPct = 100;
        run(15);

        // Redirect with responses outstanding on a slow memory.
        lat = 3;
        run(8);
        step(1'b1, 32'h0000_0100);
        run(15);
        checkEq("redirFirstPc", firstPc, 32'h0000_0100);

        // Redirect while a response arrives; back-to-back redirects.
        lat = 1;
        run(6);
        step(1'b1, 32'h0000_0040);
        step(1'b1, 32'h0000_0080);
        run(10);
        checkEq("b2bFirstPc", firstPc, 32'h0000_0080);

        // Zero-latency memory, including a redirect.
        lat = 0;
        run(10);
        step(1'b1, 32'h0000_0300);
        run(10);
        checkEq("lat0FirstPc", firstPc, 32'h0000_0300);

        // Misaligned redirect target and PC wrap-around.
        lat = 1;
        step(1'b1, 32'h0000_0203);
        run(8);
        checkEq("alignFirstPc", firstPc, 32'h0000_0200);
        step(1'b1, 32'hFFFF_FFF4);
        run(12);

        // Random back-pressure, latency and redirects.
        memReadyPct = 70; idReadyPct = 60;
        for (int i = 0; i < 250; i++) begin
            lat = int'($urandom_range(3));
            if ($urandom_range(99) < 3) step(1'b1, $urandom & 32'h0000_FFFF);
            else step(1'b0, 32'd0);
        end

        // Control-transfer stream, then reset mid-stream.
        memReadyPct = 100; idReadyPct = 100; lat = 1;
        usePdTable = 1'b1;
        doReset();
        run(8);
        doReset();
        run(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
